// File: rtl/mc_pkg.sv
// mc_pkg: shared states, opcodes, ALU codes and mux selects for the multicycle MIPS controller
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_BNE    = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12,
        S_JAL    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OPC   = 2'b11;

    localparam logic [2:0] AC_AND = 3'b000;
    localparam logic [2:0] AC_OR  = 3'b001;
    localparam logic [2:0] AC_ADD = 3'b010;
    localparam logic [2:0] AC_SUB = 3'b110;
    localparam logic [2:0] AC_SLT = 3'b111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_4     = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Returning S_FETCH from DECODE doubles as the illegal-opcode indication
    function automatic state_t decode_next(input logic [5:0] op, input logic ext);
        case (op)
            OP_LW, OP_SW:              decode_next = S_MEMADR;
            OP_RTYPE:                  decode_next = S_EXEC;
            OP_BEQ:                    decode_next = S_BEQ;
            OP_J:                      decode_next = S_JUMP;
            OP_BNE:                    decode_next = ext ? S_BNE : S_FETCH;
            OP_ADDI, OP_ANDI, OP_ORI:  decode_next = ext ? S_IMMEX : S_FETCH;
            OP_JAL:                    decode_next = ext ? S_JAL : S_FETCH;
            default:                   decode_next = S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: maps aluop plus funct/opcode to the ALU operation code
module alu_ctrl_dec
    import mc_pkg::*;
#(
    parameter int ALUCTL_W = 3
) (
    input  logic [1:0]          aluop_i,
    input  logic [5:0]          funct_i,
    input  logic [5:0]          op_i,
    output logic [ALUCTL_W-1:0] alucontrol_o
);

    logic [2:0] f_code;
    logic [2:0] o_code;
    logic [2:0] code;

    always_comb begin
        f_code = (funct_i == FN_SUB) ? AC_SUB :
                 (funct_i == FN_AND) ? AC_AND :
                 (funct_i == FN_OR)  ? AC_OR  :
                 (funct_i == FN_SLT) ? AC_SLT : AC_ADD;
        o_code = (op_i == OP_ANDI) ? AC_AND :
                 (op_i == OP_ORI)  ? AC_OR  : AC_ADD;
        code   = (aluop_i == ALUOP_ADD)   ? AC_ADD :
                 (aluop_i == ALUOP_SUB)   ? AC_SUB :
                 (aluop_i == ALUOP_FUNCT) ? f_code : o_code;
    end

    assign alucontrol_o = ALUCTL_W'(code);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS control FSM driving datapath enables, muxes and ALU control
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int ALUCTL_W = 3,
    parameter int EXT_OPS  = 1,
    parameter int MEM_WAIT = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                iord,
    output logic                memread,
    output logic                memwrite,
    output logic                irwrite,
    output logic [1:0]          memtoreg,
    output logic [1:0]          regdst,
    output logic                regwrite,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic                zeroext,
    output logic [ALUCTL_W-1:0] alucontrol,
    output logic [1:0]          pcsrc,
    output logic                pcen,
    output logic                illegal,
    output logic [3:0]          state_o
);

    state_t     state_q;
    state_t     state_d;
    state_t     dec_next;
    logic       rdy;
    logic       pcwrite;
    logic       branch;
    logic       branchne;
    logic [1:0] aluop;

    assign rdy      = (MEM_WAIT == 0) | mem_ready;
    assign dec_next = decode_next(op, EXT_OPS != 0);
    assign state_o  = state_q;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE: state_d = dec_next;
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = rdy ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_IMMEX:  state_d = S_IMMWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        iord     = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        memtoreg = WB_ALU;
        regdst   = RD_RT;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_B;
        zeroext  = 1'b0;
        aluop    = ALUOP_ADD;
        pcsrc    = PC_ALU;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        branchne = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = SRCB_4;
                irwrite = rdy;
                pcwrite = rdy;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
                illegal = (dec_next == S_FETCH);
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = WB_MEM;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst   = RD_RD;
                regwrite = 1'b1;
            end
            S_BEQ, S_BNE: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_SUB;
                pcsrc    = PC_ALUOUT;
                branch   = (state_q == S_BEQ);
                branchne = (state_q == S_BNE);
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluop   = (op == OP_ADDI) ? ALUOP_ADD : ALUOP_OPC;
                zeroext = (op != OP_ADDI);
            end
            S_IMMWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = PC_JUMP;
                pcwrite = 1'b1;
            end
            S_JAL: begin
                pcsrc    = PC_JUMP;
                pcwrite  = 1'b1;
                regdst   = RD_R31;
                memtoreg = WB_PC;
                regwrite = 1'b1;
            end
            default: ;
        endcase
        // Side-effecting strobes are held off for the whole time reset is asserted
        memread  = memread & reset_n;
        memwrite = memwrite & reset_n;
        irwrite  = irwrite & reset_n;
        regwrite = regwrite & reset_n;
        illegal  = illegal & reset_n;
        pcen     = reset_n & (pcwrite | (branch & zero) | (branchne & ~zero));
    end

    alu_ctrl_dec #(
        .ALUCTL_W(ALUCTL_W)
    ) u_alu_ctrl_dec (
        .aluop_i      (aluop),
        .funct_i      (funct),
        .op_i         (op),
        .alucontrol_o (alucontrol)
    );

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: scoreboard bench for mc_ctrl_fsm, plus an EXT_OPS=0/MEM_WAIT=0/4-bit-ALU variant
module tb_mc_ctrl_fsm;

    localparam int F_ST = 0, F_IRW = 1, F_PCEN = 2, F_RW = 3, F_MTR = 4, F_RDST = 5, F_AC = 6;
    localparam int F_ZX = 7, F_SRCB = 8, F_PCSRC = 9, F_ILL = 10, F_MW = 11, F_MR = 12;
    localparam int F_ST0 = 13, F_ILL0 = 14, F_RW0 = 15, F_IRW0 = 16, F_AC0 = 17;

    typedef struct {
        int          cyc;
        string       tag;
        int          fld;
        logic [31:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic       iord, memread, memwrite, irwrite, regwrite, alusrca, zeroext, pcen, illegal;
    logic [1:0] memtoreg, regdst, alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state_o;

    logic       iord0, memread0, memwrite0, irwrite0, regwrite0, alusrca0, zeroext0, pcen0, illegal0;
    logic [1:0] memtoreg0, regdst0, alusrcb0, pcsrc0;
    logic [3:0] alucontrol0;
    logic [3:0] state0;

    exp_t sb[$];
    int   cyc_n = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .zeroext(zeroext), .alucontrol(alucontrol), .pcsrc(pcsrc),
        .pcen(pcen), .illegal(illegal), .state_o(state_o)
    );

    mc_ctrl_fsm #(.ALUCTL_W(4), .EXT_OPS(0), .MEM_WAIT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(iord0), .memread(memread0), .memwrite(memwrite0), .irwrite(irwrite0),
        .memtoreg(memtoreg0), .regdst(regdst0), .regwrite(regwrite0), .alusrca(alusrca0),
        .alusrcb(alusrcb0), .zeroext(zeroext0), .alucontrol(alucontrol0), .pcsrc(pcsrc0),
        .pcen(pcen0), .illegal(illegal0), .state_o(state0)
    );

    function automatic logic [31:0] obs(input int f);
        case (f)
            F_ST:    obs = 32'(state_o);
            F_IRW:   obs = 32'(irwrite);
            F_PCEN:  obs = 32'(pcen);
            F_RW:    obs = 32'(regwrite);
            F_MTR:   obs = 32'(memtoreg);
            F_RDST:  obs = 32'(regdst);
            F_AC:    obs = 32'(alucontrol);
            F_ZX:    obs = 32'(zeroext);
            F_SRCB:  obs = 32'(alusrcb);
            F_PCSRC: obs = 32'(pcsrc);
            F_ILL:   obs = 32'(illegal);
            F_MW:    obs = 32'(memwrite);
            F_MR:    obs = 32'(memread);
            F_ST0:   obs = 32'(state0);
            F_ILL0:  obs = 32'(illegal0);
            F_RW0:   obs = 32'(regwrite0);
            F_IRW0:  obs = 32'(irwrite0);
            F_AC0:   obs = 32'(alucontrol0);
            default: obs = 'x;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic ex(input int off, input string tag, input int fld, input logic [31:0] v);
        sb.push_back('{cyc_n + off, $sformatf("%s@%0d", tag, off), fld, v});
    endtask

    // Drive one cycle's inputs, retire every expectation due this cycle, then move to the next negedge
    task automatic cycle(input logic rst_v, input logic rdy_v, input logic z_v);
        reset_n = rst_v;
        mem_ready = rdy_v;
        zero = z_v;
        #1;
        for (int i = 0; i < sb.size(); ) begin
            if (sb[i].cyc == cyc_n) begin
                chk(sb[i].tag, obs(sb[i].fld), sb[i].val);
                sb.delete(i);
            end else i++;
        end
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic [31:0] rdy, input logic z);
        for (int i = 0; i < n; i++) cycle(1'b1, rdy[i], z);
    endtask

    task automatic do_r(input logic [5:0] f, input logic [31:0] ac);
        op = 6'b000000;
        funct = f;
        ex(0, "r_st", F_ST, 0);
        ex(0, "r_irw", F_IRW, 1);
        ex(0, "r_pcen", F_PCEN, 1);
        ex(1, "r_st", F_ST, 1);
        ex(2, "r_st", F_ST, 6);
        ex(2, "r_ac", F_AC, ac);
        ex(2, "r_rw", F_RW, 0);
        ex(3, "r_st", F_ST, 7);
        ex(3, "r_rdst", F_RDST, 1);
        ex(3, "r_rw", F_RW, 1);
        run(4, 32'hF, 1'b0);
    endtask

    task automatic do_lw();
        logic [3:0] st[11] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4, 0};
        op = 6'b100011;
        for (int i = 0; i < 11; i++) begin
            ex(i, "lw_st", F_ST, 32'(st[i]));
            ex(i, "lw_rw", F_RW, (i == 9) ? 1 : 0);
        end
        ex(0, "lw_irw", F_IRW, 0);
        ex(0, "lw_pcen", F_PCEN, 0);
        ex(2, "lw_irw", F_IRW, 1);
        ex(5, "lw_mr", F_MR, 1);
        ex(9, "lw_mtr", F_MTR, 1);
        run(11, 32'b01100011100, 1'b0);
    endtask

    task automatic do_sw();
        op = 6'b101011;
        ex(0, "sw_st", F_ST, 0);
        ex(1, "sw_st", F_ST, 1);
        ex(2, "sw_st", F_ST, 2);
        ex(3, "sw_st", F_ST, 5);
        ex(3, "sw_mw", F_MW, 1);
        ex(3, "sw_rw", F_RW, 0);
        run(4, 32'hF, 1'b0);
    endtask

    task automatic do_br(input logic [5:0] o, input logic z, input logic [31:0] st, input logic [31:0] pe);
        op = o;
        ex(0, "br_st", F_ST, 0);
        ex(1, "br_st", F_ST, 1);
        ex(2, "br_st", F_ST, st);
        ex(2, "br_pcen", F_PCEN, pe);
        ex(2, "br_pcsrc", F_PCSRC, 1);
        run(3, 32'h7, z);
    endtask

    task automatic do_imm(input logic [5:0] o, input logic [31:0] ac, input logic [31:0] zx);
        op = o;
        ex(0, "imm_st", F_ST, 0);
        ex(1, "imm_st", F_ST, 1);
        ex(2, "imm_st", F_ST, 10);
        ex(2, "imm_ac", F_AC, ac);
        ex(2, "imm_zx", F_ZX, zx);
        ex(2, "imm_srcb", F_SRCB, 2);
        ex(2, "imm_rw", F_RW, 0);
        ex(3, "imm_st", F_ST, 11);
        ex(3, "imm_rw", F_RW, 1);
        ex(3, "imm_rdst", F_RDST, 0);
        ex(3, "imm_mtr", F_MTR, 0);
        run(4, 32'hF, 1'b0);
    endtask

    task automatic do_j(input logic jal);
        op = jal ? 6'b000011 : 6'b000010;
        ex(0, "j_st", F_ST, 0);
        ex(1, "j_st", F_ST, 1);
        ex(2, "j_st", F_ST, jal ? 13 : 12);
        ex(2, "j_pcen", F_PCEN, 1);
        ex(2, "j_pcsrc", F_PCSRC, 2);
        ex(2, "j_rw", F_RW, 32'(jal));
        if (jal) begin
            ex(2, "jal_rdst", F_RDST, 2);
            ex(2, "jal_mtr", F_MTR, 2);
        end
        run(3, 32'h7, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        op = 6'b000000;
        funct = 6'b100000;
        ex(0, "rst_st", F_ST, 0);
        ex(0, "rst_irw", F_IRW, 0);
        ex(0, "rst_pcen", F_PCEN, 0);
        ex(0, "rst_mr", F_MR, 0);
        cycle(1'b0, 1'b1, 1'b0);
        ex(0, "pre_st", F_ST, 0);
        ex(1, "pre_st", F_ST, 1);
        ex(2, "pre_st", F_ST, 6);
        ex(3, "midrst_st", F_ST, 0);
        ex(3, "midrst_rw", F_RW, 0);
        ex(3, "midrst_pcen", F_PCEN, 0);
        run(3, 32'h7, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        do_r(6'b100000, 3'b010);
        do_lw();
        do_r(6'b100000, 3'b010);
        do_r(6'b101010, 3'b111);
        do_r(6'b100010, 3'b110);
        do_sw();
        do_br(6'b000100, 1'b1, 8, 1);
        do_br(6'b000101, 1'b1, 9, 0);
        do_br(6'b000101, 1'b0, 9, 1);
        do_imm(6'b001101, 3'b001, 1);
        do_imm(6'b001100, 3'b000, 1);
        do_imm(6'b001000, 3'b010, 0);
        do_j(1'b1);
        do_j(1'b0);
        op = 6'b111111;
        ex(0, "ill_st", F_ST, 0);
        ex(0, "ill_ill", F_ILL, 0);
        ex(1, "ill_st", F_ST, 1);
        ex(1, "ill_ill", F_ILL, 1);
        ex(1, "ill_rw", F_RW, 0);
        ex(1, "ill_mw", F_MW, 0);
        ex(2, "ill_st", F_ST, 0);
        ex(2, "ill_ill", F_ILL, 0);
        run(3, 32'b011, 1'b0);
        op = 6'b001000;
        ex(0, "v0rst_st0", F_ST0, 0);
        cycle(1'b0, 1'b1, 1'b0);
        ex(0, "v0_st", F_ST, 0);
        ex(0, "v0_irw", F_IRW, 0);
        ex(0, "v0_st0", F_ST0, 0);
        ex(0, "v0_irw0", F_IRW0, 1);
        ex(1, "v0_st", F_ST, 0);
        ex(1, "v0_ill", F_ILL, 0);
        ex(1, "v0_st0", F_ST0, 1);
        ex(1, "v0_ill0", F_ILL0, 1);
        ex(1, "v0_ac0", F_AC0, 4'b0010);
        ex(1, "v0_rw0", F_RW0, 0);
        ex(2, "v0_st", F_ST, 1);
        ex(2, "v0_st0", F_ST0, 0);
        ex(2, "v0_ill0", F_ILL0, 0);
        run(3, 32'b010, 1'b0);
        chk("sb_drain", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
